// File: rtl/green_track_if.sv
// green_track_if: pixel stream in, tracking results and thresholds out.
interface green_track_if;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       sof;
  logic       eof;
  logic       greencheck;
  logic [9:0] red_threshold;
  logic [9:0] blue_threshold;
  logic [19:0] green_count;
  logic [9:0] box_xmin;
  logic [9:0] box_xmax;
  logic [9:0] box_ymin;
  logic [9:0] box_ymax;
  logic       target_found;
  logic       result_valid;
  modport master (
    output pix_valid, pix_x, pix_y, sof, eof, greencheck,
    input  red_threshold, blue_threshold, green_count,
    input  box_xmin, box_xmax, box_ymin, box_ymax, target_found, result_valid
  );
  modport slave (
    input  pix_valid, pix_x, pix_y, sof, eof, greencheck,
    output red_threshold, blue_threshold, green_count,
    output box_xmin, box_xmax, box_ymin, box_ymax, target_found, result_valid
  );
endinterface

// File: rtl/green_track_ctrl.sv
// green_track_ctrl: per-frame green-pixel count and bounding box with detector threshold feedback.
// Define GREEN_AUTO_THRESH_EN to enable per-frame red/blue threshold adjustment.
module green_track_ctrl #(
  parameter logic [9:0]  RED_INIT  = 10'd600,
  parameter logic [9:0]  BLUE_INIT = 10'd300,
  parameter logic [9:0]  STEP      = 10'd8,
  parameter logic [19:0] COUNT_LO  = 20'd500,
  parameter logic [19:0] COUNT_HI  = 20'd20000,
  parameter logic [19:0] MIN_COUNT = 20'd64
) (
  input logic clk,
  input logic rst_n,
  green_track_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, UPDATE} state_t;
  state_t state_q;
  logic pv_q, found_q, rv_q;
  logic [9:0] px_q, py_q, xmin_q, xmax_q, ymin_q, ymax_q;
  logic [9:0] bxmin_q, bxmax_q, bymin_q, bymax_q;
  logic [9:0] red_q, blue_q, red_d, blue_d;
  logic [19:0] cnt_q, gcnt_q;
  logic hit, restart;
  // greencheck lags the pixel by one cycle, so it pairs with the delayed x/y
  assign hit = pv_q && bus.greencheck && (state_q == ACCUM || state_q == DRAIN);
  assign restart = bus.sof && (state_q == IDLE || (state_q == ACCUM && !bus.eof));
`ifdef GREEN_AUTO_THRESH_EN
  logic [10:0] red_up, red_dn, blue_up, blue_dn;
  always_comb begin
    red_up  = {1'b0, red_q} + {1'b0, STEP};
    red_dn  = {1'b0, red_q} - {1'b0, STEP};
    blue_up = {1'b0, blue_q} + {1'b0, STEP};
    blue_dn = {1'b0, blue_q} - {1'b0, STEP};
    red_d  = cnt_q < COUNT_LO ? (red_dn[10] ? 10'd0 : red_dn[9:0])
           : cnt_q > COUNT_HI ? (red_up[10] ? 10'h3FF : red_up[9:0]) : red_q;
    blue_d = cnt_q < COUNT_LO ? (blue_up[10] ? 10'h3FF : blue_up[9:0])
           : cnt_q > COUNT_HI ? (blue_dn[10] ? 10'd0 : blue_dn[9:0]) : blue_q;
  end
`else
  assign red_d  = red_q;
  assign blue_d = blue_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pv_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= '0;
      xmin_q  <= 10'h3FF;
      ymin_q  <= 10'h3FF;
      xmax_q  <= '0;
      ymax_q  <= '0;
      red_q   <= RED_INIT;
      blue_q  <= BLUE_INIT;
      gcnt_q  <= '0;
      bxmin_q <= '0;
      bxmax_q <= '0;
      bymin_q <= '0;
      bymax_q <= '0;
      found_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      pv_q <= bus.pix_valid;
      px_q <= bus.pix_x;
      py_q <= bus.pix_y;
      rv_q <= 1'b0;
      case (state_q)
        IDLE:  state_q <= bus.sof ? ACCUM : IDLE;
        ACCUM: state_q <= bus.eof ? DRAIN : ACCUM;
        DRAIN: state_q <= UPDATE;
        default: begin
          state_q <= IDLE;
          rv_q    <= 1'b1;
          gcnt_q  <= cnt_q;
          found_q <= cnt_q >= MIN_COUNT;
          bxmin_q <= cnt_q >= MIN_COUNT ? xmin_q : 10'd0;
          bxmax_q <= cnt_q >= MIN_COUNT ? xmax_q : 10'd0;
          bymin_q <= cnt_q >= MIN_COUNT ? ymin_q : 10'd0;
          bymax_q <= cnt_q >= MIN_COUNT ? ymax_q : 10'd0;
          red_q   <= red_d;
          blue_q  <= blue_d;
        end
      endcase
      if (restart) begin
        cnt_q  <= '0;
        xmin_q <= 10'h3FF;
        ymin_q <= 10'h3FF;
        xmax_q <= '0;
        ymax_q <= '0;
      end else if (hit) begin
        cnt_q  <= cnt_q == 20'hFFFFF ? cnt_q : cnt_q + 20'd1;
        xmin_q <= px_q < xmin_q ? px_q : xmin_q;
        xmax_q <= px_q > xmax_q ? px_q : xmax_q;
        ymin_q <= py_q < ymin_q ? py_q : ymin_q;
        ymax_q <= py_q > ymax_q ? py_q : ymax_q;
      end
    end
  end
  assign bus.red_threshold  = red_q;
  assign bus.blue_threshold = blue_q;
  assign bus.green_count    = gcnt_q;
  assign bus.box_xmin       = bxmin_q;
  assign bus.box_xmax       = bxmax_q;
  assign bus.box_ymin       = bymin_q;
  assign bus.box_ymax       = bymax_q;
  assign bus.target_found   = found_q;
  assign bus.result_valid   = rv_q;
endmodule

// File: doc/green_track_ctrl.md
GREEN_TRACK_CTRL -- requirements
Module: green_track_ctrl

Interface
REQ-001 Parameter RED_INIT, 10'd600, red_threshold reset/static value; SHALL be honoured.
REQ-002 Parameter BLUE_INIT, 10'd300, blue_threshold reset/static value; SHALL be honoured.
REQ-003 Parameter STEP, 10'd8, per-frame threshold adjustment step; SHALL be honoured.
REQ-004 Parameters COUNT_LO 20'd500, COUNT_HI 20'd20000, MIN_COUNT 20'd64 (green-count bands); SHALL be honoured.
REQ-005 Ports SHALL be, clock and reset first; all other ports synchronous to clk:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel x/y valid this cycle.
- pix_x  in  10  pixel column.
- pix_y  in  10  pixel row.
- sof  in  1  start-of-frame pulse.
- eof  in  1  end-of-frame pulse, coincident with or after last pixel.
- greencheck  in  1  detector result, one cycle behind pix_valid.
- red_threshold  out  10  to detector.
- blue_threshold  out  10  to detector.
- green_count  out  20  published green-pixel count.
- box_xmin, box_xmax, box_ymin, box_ymax  out  10 each  published bounding box.
- target_found  out  1  published count >= MIN_COUNT.
- result_valid  out  1  one-cycle publish strobe.

Function
REQ-006 FSM states SHALL be IDLE, ACCUM, DRAIN, UPDATE; IDLE->ACCUM on sof; ACCUM->DRAIN on eof; DRAIN->UPDATE unconditionally; UPDATE->IDLE unconditionally.
REQ-007 pix_valid, pix_x, pix_y SHALL be delayed one register stage and paired with greencheck of the following cycle.
REQ-008 On sof in IDLE or ACCUM, working count SHALL clear to 0, working xmin/ymin to 1023, xmax/ymax to 0; sof in ACCUM restarts the frame.
REQ-009 In ACCUM and DRAIN, each delayed-valid pixel with greencheck=1 SHALL increment working count (saturating at 20'hFFFFF) and update min/max with delayed x/y.
REQ-010 sof in DRAIN/UPDATE and eof outside ACCUM SHALL be ignored; sof and eof in the same ACCUM cycle: eof wins.
REQ-011 On the UPDATE edge, green_count SHALL take working count; if count >= MIN_COUNT, box outputs take working box and target_found=1, else box outputs=0 and target_found=0.
REQ-012 result_valid SHALL be high exactly the one cycle following the UPDATE edge; frame-end-to-strobe latency from eof edge = 3 cycles.
REQ-013 Thresholds SHALL change only on the UPDATE edge, constant during ACCUM.
REQ-014 Adjustment: count < COUNT_LO -> red -= STEP (floor 0), blue += STEP (ceiling 1023); count > COUNT_HI -> red += STEP (ceiling 1023), blue -= STEP (floor 0); otherwise unchanged; 11-bit intermediate arithmetic, no wrap.

Reset
REQ-015 rst_n low SHALL asynchronously force state IDLE, pipeline valid 0, working registers to frame-start values, red_threshold=RED_INIT, blue_threshold=BLUE_INIT, green_count=0, box outputs=0, target_found=0, result_valid=0.
REQ-016 Reset mid-frame SHALL discard the partial frame; no result_valid until a full sof..eof frame completes.

Configuration
REQ-017 With GREEN_AUTO_THRESH_EN defined, REQ-014 adjustment SHALL be active.
REQ-018 Without GREEN_AUTO_THRESH_EN, thresholds SHALL stay at RED_INIT/BLUE_INIT permanently; all other behaviour identical.

Verification
REQ-019 Frame of 100 green pixels at x 10..19, y 5..14 -> green_count=100, box 10/19/5/14, target_found=1, result_valid one cycle, 3 cycles after eof.
REQ-020 Frame with 20 green pixels (AUTO_EN) -> target_found=0, box all 0, red 600->592, blue 300->308.
REQ-021 Frame with 30000 green pixels (AUTO_EN) -> red 608, blue 292; repeat until red saturates at 1023 exactly, no wrap.
REQ-022 sof mid-ACCUM after 50 greens, then 10 greens, eof -> green_count=10; rst_n pulse mid-frame -> no strobe, outputs at reset values.
REQ-023 Last pixel coincident with eof, greencheck=1 next cycle -> pixel counted; build without macro -> thresholds fixed at 600/300 across all frames.
